// File: rtl/serial_sub.sv
// serial_sub: bit-serial N-bit subtractor, diff = a - b - b_in, LSB first.
// A single full-subtractor cell walks the captured operands one bit per
// clock. A start/busy/done handshake lets a controller issue back-to-back
// operations. diff/b_out/ovf are registered and change only on entry to DONE.
module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operand shift registers, result accumulator and running borrow
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    // Operand sign bits kept for the overflow test at the end
    logic             a_msb;
    logic             b_msb;

    // Control from the FSM
    logic             load;
    logic             step;
    logic             last_bit;

    // Full-subtractor cell
    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             br_nxt;

    assign last_bit = (cnt == LAST_BIT);

    // Full-subtractor on the current LSBs and the running borrow
    always_comb begin
        a0     = a_sr[0];
        b0     = b_sr[0];
        d_bit  = a0 ^ b0 ^ br;
        br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; start is honoured only in IDLE or DONE
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and one-bit-per-cycle datapath advance
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= b_in;
            cnt    <= '0;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
        end else if (step) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {d_bit, res_sr[WIDTH-1:1]};
            br     <= br_nxt;
            cnt    <= cnt + 1'b1;
        end
    end

    // Result registers: loaded from the last bit's cell outputs so they
    // are valid in the DONE cycle itself; held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            diff  <= '0;
            b_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (step && last_bit) begin
            diff  <= {d_bit, res_sr[WIDTH-1:1]};
            b_out <= br_nxt;
            ovf   <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: randomized self-checking bench for serial_sub, WIDTH=4 and WIDTH=8.
// Expected results come from an integer-arithmetic reference of a - b - b_in.
module tb_serial_sub;

    logic       clk;
    logic       rst;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       bin4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bout4;
    logic       ovf4;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       bin8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bout8;
    logic       ovf8;

    int         n_checks;
    int         n_errors;
    logic [3:0] prev4_diff;

    serial_sub #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .b_in  (bin4),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
        .b_out (bout4),
        .ovf   (ovf4)
    );

    serial_sub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .b_in  (bin8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .b_out (bout8),
        .ovf   (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction, unsigned borrow and signed range test
    function automatic void ref_sub(input int w, input longint av, input longint bv, input int bi,
                                    output longint d, output bit bo, output bit ov);
        longint full;
        longint sa;
        longint sb;
        longint s;
        longint half;
        half = longint'(1) << (w - 1);
        full = av - bv - longint'(bi);
        d    = full & ((longint'(1) << w) - 1);
        bo   = (full < 0);
        sa   = (av >= half) ? av - 2 * half : av;
        sb   = (bv >= half) ? bv - 2 * half : bv;
        s    = sa - sb - longint'(bi);
        ov   = (s < -half) || (s > half - 1);
    endfunction

    task automatic wait_done4(output int cyc);
        cyc = 0;
        while (!done4 && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    // One WIDTH=4 operation with latency, busy-length, hold and capture checks
    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic bi);
        longint ed;
        bit     eb;
        bit     eo;
        int     cyc;
        int     busy_n;
        ref_sub(4, longint'(av), longint'(bv), int'(bi), ed, eb, eo);
        @(negedge clk);
        a4 = av; b4 = bv; bin4 = bi; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("hold_diff4", 32'(diff4), 32'(prev4_diff));
        busy_n = 0;
        cyc    = 0;
        while (!done4 && cyc < 20) begin
            if (busy4) busy_n++;
            a4   = 4'($urandom);
            b4   = 4'($urandom);
            bin4 = 1'($urandom);
            cyc++;
            @(negedge clk);
        end
        check("latency4", 32'(cyc), 32'd4);
        check("busy_len4", 32'(busy_n), 32'd4);
        check("diff4", 32'(diff4), 32'(ed));
        check("b_out4", 32'(bout4), 32'(eb));
        check("ovf4", 32'(ovf4), 32'(eo));
        prev4_diff = ed[3:0];
        @(negedge clk);
        check("done_pulse4", 32'(done4), 32'd0);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        longint ed;
        bit     eb;
        bit     eo;
        int     cyc;
        ref_sub(8, longint'(av), longint'(bv), int'(bi), ed, eb, eo);
        @(negedge clk);
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc = 0;
        while (!done8 && cyc < 30) begin
            cyc++;
            @(negedge clk);
        end
        check("latency8", 32'(cyc), 32'd8);
        check("diff8", 32'(diff8), 32'(ed));
        check("b_out8", 32'(bout8), 32'(eb));
        check("ovf8", 32'(ovf8), 32'(eo));
    endtask

    initial begin
        int cyc;
        int gap;
        int dones;
        n_checks = 0;
        n_errors = 0;
        prev4_diff = '0;
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_done", 32'(done4), 32'd0);
        check("rst_diff", 32'(diff4), 32'd0);
        check("rst_bout", 32'(bout4), 32'd0);
        check("rst_ovf", 32'(ovf4), 32'd0);
        check("rst_diff8", 32'(diff8), 32'd0);
        rst = 1'b0;

        // Directed vectors
        op4(4'b1001, 4'b1101, 1'b0);
        op4(4'b0011, 4'b0101, 1'b1);
        op4(4'b1111, 4'b1111, 1'b1);
        op4(4'b0111, 4'b1000, 1'b0);
        op4(4'b0000, 4'b0000, 1'b0);

        // Back-to-back: start held through the DONE cycle
        @(negedge clk);
        a4 = 4'b1010; b4 = 4'b0001; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(cyc);
        check("b2b_first_diff", 32'(diff4), 32'd9);
        a4 = 4'b0101; b4 = 4'b0010; bin4 = 1'b0; start4 = 1'b1;
        gap = 0;
        do begin
            @(negedge clk);
            start4 = 1'b0;
            gap++;
        end while (!done4 && gap < 20);
        check("b2b_gap", 32'(gap), 32'd5);
        check("b2b_diff", 32'(diff4), 32'd3);
        check("b2b_bout", 32'(bout4), 32'd0);
        check("b2b_ovf", 32'(ovf4), 32'd0);
        prev4_diff = 4'd3;

        // start pulsed during SHIFT is ignored
        @(negedge clk);
        a4 = 4'b0110; b4 = 4'b0011; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        a4 = 4'b1111; b4 = 4'b0000; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(cyc);
        check("ign_latency", 32'(cyc), 32'd2);
        check("ign_diff", 32'(diff4), 32'd3);
        check("ign_bout", 32'(bout4), 32'd0);
        @(negedge clk);
        check("ign_no_rerun", 32'(busy4), 32'd0);
        prev4_diff = 4'd3;

        // Reset on the second SHIFT cycle abandons the operation
        @(negedge clk);
        a4 = 4'b1000; b4 = 4'b0001; bin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy4), 32'd0);
        check("midrst_done", 32'(done4), 32'd0);
        check("midrst_diff", 32'(diff4), 32'd0);
        check("midrst_bout", 32'(bout4), 32'd0);
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (done4) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        prev4_diff = '0;
        op4(4'b0101, 4'b0011, 1'b1);

        // rst and start together: rst wins
        @(negedge clk);
        rst = 1'b1; start4 = 1'b1; a4 = 4'b0100; b4 = 4'b0001;
        @(negedge clk);
        rst = 1'b0; start4 = 1'b0;
        @(negedge clk);
        check("rst_start_busy", 32'(busy4), 32'd0);
        prev4_diff = '0;

        // Exhaustive WIDTH=4
        for (int i = 0; i < 512; i++) begin
            op4(i[3:0], i[7:4], i[8]);
        end

        // Random WIDTH=8, with the corner operands mixed in
        op8(8'h80, 8'h00, 1'b1);
        op8(8'h7F, 8'h80, 1'b0);
        op8(8'h00, 8'hFF, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
